thread_mt: RTL and testbench
============================

THREAD_MT -- requirements
Module: thread_mt

Interface
REQ-001 SHALL have parameter NUM_THREADS, default 2, number of hardware thread contexts (1..8).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, PC loaded into every context at reset.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port run_en  input  NUM_THREADS  per-thread enable; 0 makes thread ineligible for scheduling.
REQ-006 SHALL have port unit_valid  output  1  unit request valid.
REQ-007 SHALL have port unit_ready  input  1  unit accepts request and presents unit_out this cycle.
REQ-008 SHALL have port unit_sel  output  unit_sel_t  target unit (MEM, ALU, NONE).
REQ-009 SHALL have port unit_ctrl  output  32  unit operation code.
REQ-010 SHALL have port unit_in0 / unit_in1  output  32 each  unit operands.
REQ-011 SHALL have port unit_out  input  32  unit result, valid when unit_valid && unit_ready.
REQ-012 SHALL have port thread_id  output  $clog2(NUM_THREADS) min 1  index of thread owning the unit bus.
REQ-013 SHALL have port halted  output  NUM_THREADS  per-thread halt flag.
REQ-014 SHALL have port retired  output  NUM_THREADS x 32  per-thread retired-instruction counts.

Function
REQ-015 SHALL hold per thread: pc, inst, private reg_file (x0 never written), phase in {FETCH, EXEC, NEXT_PC, HALT}.
REQ-016 SHALL complete a unit transaction only on a cycle with unit_valid && unit_ready; phase advances and unit_out is captured on that edge.
REQ-017 SHALL hold unit_sel, unit_ctrl, unit_in0, unit_in1, thread_id stable while unit_valid && !unit_ready.
REQ-018 FETCH SHALL issue MEM / MEM_CTRL_READ / in0=pc, capture unit_out into inst.
REQ-019 EXEC SHALL issue per opcode: AUIPC ALU ADD pc,imm->rd; JAL/JALR ALU ADD pc,4->rd; OP ALU alu_ctrl rs1,rs2->rd; OP_IMMED ALU alu_ctrl rs1,imm->rd; BRANCH ALU alu_ctrl rs1,rs2, taken = unit_out[0].
REQ-020 LUI EXEC SHALL write imm to rd in one cycle with unit_valid=0.
REQ-021 NEXT_PC SHALL issue ALU ADD with pc,imm for JAL or taken BRANCH; rs1,imm for JALR with result bit0 cleared; otherwise pc,4; result loads pc.
REQ-022 ENV or unknown opcode in EXEC SHALL set phase HALT and halted[t]=1 with no unit request; pc unchanged.
REQ-023 PC arithmetic SHALL wrap modulo 2^32.
REQ-024 Scheduling SHALL be round-robin at instruction granularity: after NEXT_PC completes or a thread halts, ownership moves to the next index (mod NUM_THREADS) with run_en=1 and halted=0, searching from current+1 and including current last.
REQ-025 With no eligible thread, unit_valid SHALL be 0 and thread_id SHALL hold; scheduling resumes the cycle after any thread becomes eligible.
REQ-026 run_en deasserted mid-instruction SHALL NOT abort it; the instruction completes, then the thread is skipped.
REQ-027 retired[t] SHALL increment by 1 on completion of NEXT_PC of thread t, wrapping at 2^32.
REQ-028 unit_ready asserted in the same cycle as unit_valid SHALL give single-cycle transactions (fetch-exec-next_pc = 3 cycles, LUI = 3 cycles).

Reset
REQ-029 rst_n low SHALL immediately force unit_valid=0, unit_sel=NONE, unit_ctrl=0, unit_in0=unit_in1=0, thread_id=0, halted=0, retired=0.
REQ-030 On reset all pc=RESET_PC, inst=0, phase=FETCH; reset mid-transaction SHALL abandon it without register writes.
REQ-031 Register-file contents SHALL NOT be cleared by reset.

Configuration
REQ-032 Macro THREAD_MT_RETIRE_CNT_EN defined SHALL implement retired counters per REQ-027.
REQ-033 Macro THREAD_MT_RETIRE_CNT_EN undefined SHALL tie retired to 0 and remove counter logic; all other behaviour identical.

Verification
REQ-034 NUM_THREADS=2, unit_ready=1, t0 "LUI x1,0x12345", t1 "ADDI x2,x0,7" -> thread_id 0 for 3 cycles then 1; t0 x1=0x12345000, t1 x2=7, both pc=4.
REQ-035 unit_ready low 4 cycles during t0 FETCH -> outputs stable all 4 cycles, inst captured only on ready edge.
REQ-036 t0 "BEQ x0,x0,+16" at pc 0x8 -> pc=0x18; "BNE x0,x0,+16" -> pc=0xC.
REQ-037 t0 x5=0x103, "JALR x1,4(x5)" at pc 0x20 -> x1=0x24, pc=0x106; pc 0xFFFF_FFFC plain op -> pc=0.
REQ-038 t1 executes EBREAK -> halted=2'b10, thereafter only thread 0 scheduled; run_en=0 for both -> unit_valid=0.
REQ-039 rst_n low while unit_valid=1, unit_ready=0 -> unit_valid=0 same cycle; after release pc=RESET_PC, retired=0.

Source files
------------

// File: rtl/thread_mt_if.sv
// Unit-bus types and the thread_mt unit request/response interface.
package thread_mt_pkg;
   typedef enum logic [1:0] {NONE = 2'd0, MEM = 2'd1, ALU = 2'd2} unit_sel_t;
   localparam logic [31:0] MEM_CTRL_READ = 32'h0000_0000;
   localparam logic [31:0] ALU_ADD       = 32'h0000_0000;
   // Comparison ops are ALU_BRANCH | funct3; the unit returns the outcome in bit 0.
   localparam logic [31:0] ALU_BRANCH    = 32'h0000_0010;
endpackage

interface thread_mt_if #(parameter int unsigned NUM_THREADS = 2);
   import thread_mt_pkg::*;
   localparam int unsigned TW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
   logic            unit_valid;
   logic            unit_ready;
   unit_sel_t       unit_sel;
   logic [31:0]     unit_ctrl;
   logic [31:0]     unit_in0;
   logic [31:0]     unit_in1;
   logic [31:0]     unit_out;
   logic [TW-1:0]   thread_id;

   modport master (output unit_valid, unit_sel, unit_ctrl, unit_in0, unit_in1, thread_id,
                   input  unit_ready, unit_out);
   modport slave  (input  unit_valid, unit_sel, unit_ctrl, unit_in0, unit_in1, thread_id,
                   output unit_ready, unit_out);
endinterface

// File: rtl/thread_mt.sv
// Round-robin multithreaded RV32I sequencer sharing one external unit bus.
// Optional retired-instruction counters: define THREAD_MT_RETIRE_CNT_EN.
module thread_mt
   import thread_mt_pkg::*;
#(
   parameter int unsigned NUM_THREADS = 2,
   parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_THREADS-1:0]        run_en,
   thread_mt_if.master                   bus,
   output logic [NUM_THREADS-1:0]        halted,
   output logic [NUM_THREADS-1:0][31:0]  retired
);
   localparam int unsigned TW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
   localparam logic [6:0] OPC_LUI = 7'h37, OPC_AUIPC = 7'h17, OPC_JAL = 7'h6F,
                          OPC_JALR = 7'h67, OPC_BRANCH = 7'h63, OPC_OPIMM = 7'h13,
                          OPC_OP = 7'h33;

   typedef enum logic [1:0] {FETCH, EXEC, NEXT_PC, HALT} phase_t;

   phase_t           phase_q [NUM_THREADS];
   phase_t           phase_d [NUM_THREADS];
   logic [31:0]      pc_q    [NUM_THREADS];
   logic [31:0]      pc_d    [NUM_THREADS];
   logic [31:0]      inst_q  [NUM_THREADS];
   logic [31:0]      inst_d  [NUM_THREADS];
   logic [NUM_THREADS-1:0] taken_q, taken_d;
   logic [TW-1:0]    cur_q, cur_d;
   logic             active_q, active_d;
   logic [31:0]      rf_q [NUM_THREADS][32];

   phase_t      ph;
   logic [31:0] pc, inst, imm_i, imm_u, imm_b, imm_j, rs1v, rs2v;
   logic [6:0]  opc;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  f3;
   logic        valid, fire, exec_local, halt_now, wr_ok, wr_en, jalr, retire, handoff;
   unit_sel_t   sel;
   logic [31:0] ctrl, in0, in1, wr_data;
   logic [NUM_THREADS-1:0] elig;

   assign ph    = phase_q[cur_q];
   assign pc    = pc_q[cur_q];
   assign inst  = inst_q[cur_q];
   assign opc   = inst[6:0];
   assign rd    = inst[11:7];
   assign f3    = inst[14:12];
   assign rs1   = inst[19:15];
   assign rs2   = inst[24:20];
   assign imm_i = {{20{inst[31]}}, inst[31:20]};
   assign imm_u = {inst[31:12], 12'b0};
   assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
   assign rs1v  = (rs1 == 5'd0) ? '0 : rf_q[cur_q][rs1];
   assign rs2v  = (rs2 == 5'd0) ? '0 : rf_q[cur_q][rs2];

   // Unit request decode for the thread that currently owns the bus.
   always_comb begin
      valid = 1'b0; sel = NONE; ctrl = '0; in0 = '0; in1 = '0;
      exec_local = 1'b0; halt_now = 1'b0; wr_ok = 1'b0; jalr = 1'b0;
      if (active_q) begin
         unique case (ph)
            FETCH: begin
               valid = 1'b1; sel = MEM; ctrl = MEM_CTRL_READ; in0 = pc;
            end
            EXEC: begin
               case (opc)
                  OPC_LUI:   begin exec_local = 1'b1; wr_ok = 1'b1; end
                  OPC_AUIPC: begin valid = 1'b1; sel = ALU; in0 = pc; in1 = imm_u; wr_ok = 1'b1; end
                  OPC_JAL, OPC_JALR: begin
                     valid = 1'b1; sel = ALU; in0 = pc; in1 = 32'd4; wr_ok = 1'b1;
                  end
                  OPC_OP: begin
                     valid = 1'b1; sel = ALU; ctrl = {28'b0, inst[30], f3};
                     in0 = rs1v; in1 = rs2v; wr_ok = 1'b1;
                  end
                  OPC_OPIMM: begin
                     valid = 1'b1; sel = ALU; ctrl = {28'b0, inst[30] & (f3 == 3'b101), f3};
                     in0 = rs1v; in1 = imm_i; wr_ok = 1'b1;
                  end
                  OPC_BRANCH: begin
                     valid = 1'b1; sel = ALU; ctrl = ALU_BRANCH | {29'b0, f3};
                     in0 = rs1v; in1 = rs2v;
                  end
                  default: halt_now = 1'b1;
               endcase
            end
            NEXT_PC: begin
               valid = 1'b1; sel = ALU; ctrl = ALU_ADD;
               if (opc == OPC_JAL) begin
                  in0 = pc; in1 = imm_j;
               end else if (opc == OPC_BRANCH && taken_q[cur_q]) begin
                  in0 = pc; in1 = imm_b;
               end else if (opc == OPC_JALR) begin
                  in0 = rs1v; in1 = imm_i; jalr = 1'b1;
               end else begin
                  in0 = pc; in1 = 32'd4;
               end
            end
            HALT: ;
         endcase
      end
   end

   assign fire    = valid & bus.unit_ready;
   assign wr_en   = wr_ok & (fire | exec_local) & (rd != 5'd0);
   assign wr_data = exec_local ? imm_u : bus.unit_out;
   assign retire  = fire & (ph == NEXT_PC);
   assign handoff = retire | halt_now;

   assign bus.unit_valid = valid;
   assign bus.unit_sel   = sel;
   assign bus.unit_ctrl  = ctrl;
   assign bus.unit_in0   = in0;
   assign bus.unit_in1   = in1;
   assign bus.thread_id  = cur_q;

   always_comb begin
      int unsigned start, idx;
      logic        found;
      for (int unsigned t = 0; t < NUM_THREADS; t++) begin
         phase_d[t] = phase_q[t];
         pc_d[t]    = pc_q[t];
         inst_d[t]  = inst_q[t];
         elig[t]    = run_en[t] && (phase_q[t] != HALT);
      end
      taken_d  = taken_q;
      cur_d    = cur_q;
      active_d = active_q;
      found    = 1'b0;
      start    = 0;
      idx      = 0;
      unique case (ph)
         FETCH: if (fire) begin
            inst_d[cur_q]  = bus.unit_out;
            phase_d[cur_q] = EXEC;
         end
         EXEC: if (halt_now) begin
            phase_d[cur_q] = HALT;
         end else if (fire || exec_local) begin
            phase_d[cur_q] = NEXT_PC;
            taken_d[cur_q] = (opc == OPC_BRANCH) & bus.unit_out[0];
         end
         NEXT_PC: if (fire) begin
            pc_d[cur_q]    = jalr ? {bus.unit_out[31:1], 1'b0} : bus.unit_out;
            phase_d[cur_q] = FETCH;
         end
         HALT: ;
      endcase
      // On handoff the search starts after the owner; an idle bus restarts at the owner.
      if (halt_now) elig[cur_q] = 1'b0;
      if (handoff || !active_q) begin
         start = int'(cur_q) + (handoff ? 1 : 0);
         for (int unsigned k = 0; k < NUM_THREADS; k++) begin
            if (!found && elig[(start + k) % NUM_THREADS]) begin
               found = 1'b1;
               idx   = (start + k) % NUM_THREADS;
            end
         end
         active_d = found;
         if (found) cur_d = TW'(idx);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned t = 0; t < NUM_THREADS; t++) begin
            phase_q[t] <= FETCH;
            pc_q[t]    <= RESET_PC;
            inst_q[t]  <= '0;
         end
         taken_q  <= '0;
         cur_q    <= '0;
         active_q <= 1'b0;
      end else begin
         for (int unsigned t = 0; t < NUM_THREADS; t++) begin
            phase_q[t] <= phase_d[t];
            pc_q[t]    <= pc_d[t];
            inst_q[t]  <= inst_d[t];
         end
         taken_q  <= taken_d;
         cur_q    <= cur_d;
         active_q <= active_d;
      end
   end

   // Register files keep their contents across reset.
   always_ff @(posedge clk) begin
      if (wr_en) rf_q[cur_q][rd] <= wr_data;
   end

   always_comb begin
      for (int unsigned t = 0; t < NUM_THREADS; t++) halted[t] = (phase_q[t] == HALT);
   end

`ifdef THREAD_MT_RETIRE_CNT_EN
   logic [NUM_THREADS-1:0][31:0] retired_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      retired_q <= '0;
      else if (retire) retired_q[cur_q] <= retired_q[cur_q] + 32'd1;
   end
   assign retired = retired_q;
`else
   assign retired = '0;
`endif
endmodule

// File: tb/tb_thread_mt.sv
// Directed vector bench for thread_mt with a behavioural instruction memory and ALU.
module tb_thread_mt;
   import thread_mt_pkg::*;

   typedef struct {
      logic        rdy;
      logic [1:0]  en;
      logic        v;
      logic        tid;
      unit_sel_t   sel;
      logic [31:0] ctrl, in0, in1;
   } vec_t;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [1:0]          run_en = 2'b11;
   logic                rdy = 1'b1;
   logic [1:0]          halted;
   logic [1:0][31:0]    retired;
   logic [31:0]         imem [2][256];
   logic [31:0]         out;
   vec_t                vt[$];
   logic                tb_r = 1'b1;
   logic [1:0]          tb_e = 2'b11;
   int                  n_vec = 0;
   int                  n_bad = 0;

   thread_mt_if #(.NUM_THREADS(2)) bus();

   thread_mt #(.NUM_THREADS(2), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst_n(rst_n), .run_en(run_en), .bus(bus),
      .halted(halted), .retired(retired)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_f(input logic [31:0] c, a, b);
      case (c)
         32'h00: return a + b;
         32'h08: return a - b;
         32'h01: return a << b[4:0];
         32'h02: return {31'b0, $signed(a) < $signed(b)};
         32'h03: return {31'b0, a < b};
         32'h04: return a ^ b;
         32'h05: return a >> b[4:0];
         32'h0D: return $signed(a) >>> b[4:0];
         32'h06: return a | b;
         32'h07: return a & b;
         32'h10: return {31'b0, a == b};
         32'h11: return {31'b0, a != b};
         32'h14: return {31'b0, $signed(a) < $signed(b)};
         32'h15: return {31'b0, $signed(a) >= $signed(b)};
         32'h16: return {31'b0, a < b};
         32'h17: return {31'b0, a >= b};
         default: return 32'h0;
      endcase
   endfunction

   // Garbage on unit_out while not ready exposes early captures.
   always_comb begin
      out = 32'hBAD0_BAD0;
      if (rdy) begin
         case (bus.unit_sel)
            MEM:     out = imem[bus.thread_id][bus.unit_in0[9:2]];
            ALU:     out = alu_f(bus.unit_ctrl, bus.unit_in0, bus.unit_in1);
            default: out = 32'hBAD0_BAD0;
         endcase
      end
   end
   assign bus.unit_out   = out;
   assign bus.unit_ready = rdy;

   function automatic logic [99:0] snap();
      return {bus.unit_valid, bus.thread_id, bus.unit_sel, bus.unit_ctrl, bus.unit_in0, bus.unit_in1};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic v, input logic t, input unit_sel_t s,
                      input logic [31:0] c, input logic [31:0] a, input logic [31:0] b);
      vec_t x;
      x.rdy = tb_r; x.en = tb_e; x.v = v; x.tid = t; x.sel = s;
      x.ctrl = c; x.in0 = a; x.in1 = b;
      vt.push_back(x);
   endtask
   task automatic M(input logic t, input logic [31:0] a);
      add(1'b1, t, MEM, MEM_CTRL_READ, a, 32'h0);
   endtask
   task automatic A(input logic t, input logic [31:0] c, input logic [31:0] a, input logic [31:0] b);
      add(1'b1, t, ALU, c, a, b);
   endtask
   task automatic I(input logic t);
      add(1'b0, t, NONE, 32'h0, 32'h0, 32'h0);
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   initial begin
      for (int t = 0; t < 2; t++)
         for (int i = 0; i < 256; i++) imem[t][i] = 32'h0000_0013;
      imem[0][8'h00] = 32'h1234_50B7;  // LUI  x1,0x12345
      imem[0][8'h01] = 32'h0000_8193;  // ADDI x3,x1,0
      imem[0][8'h02] = 32'h0000_0863;  // BEQ  x0,x0,+16
      imem[0][8'h06] = 32'h1030_0293;  // ADDI x5,x0,0x103
      imem[0][8'h08] = 32'h0042_80E7;  // JALR x1,4(x5)
      imem[0][8'h41] = 32'h0000_8313;  // ADDI x6,x1,0
      imem[0][8'h42] = 32'hFFC0_0067;  // JALR x0,-4(x0)
      imem[1][8'h00] = 32'h0070_0113;  // ADDI x2,x0,7
      imem[1][8'h01] = 32'h0001_0213;  // ADDI x4,x2,0
      imem[1][8'h02] = 32'h0000_1863;  // BNE  x0,x0,+16
      imem[1][8'h03] = 32'h0010_0073;  // EBREAK

      I(0); M(0, 0); I(0); A(0, 0, 0, 4);
      M(1, 0); A(1, 0, 0, 7); A(1, 0, 0, 4);
      M(0, 4); A(0, 0, 32'h1234_5000, 0); A(0, 0, 4, 4);
      M(1, 4); A(1, 0, 7, 0); A(1, 0, 4, 4);
      tb_r = 1'b0; repeat (4) M(0, 8); tb_r = 1'b1;
      M(0, 8); A(0, 32'h10, 0, 0); A(0, 0, 8, 16);
      M(1, 8); A(1, 32'h11, 0, 0); A(1, 0, 8, 4);
      M(0, 32'h18); A(0, 0, 0, 32'h103); A(0, 0, 32'h18, 4);
      M(1, 32'hC); I(1);
      M(0, 32'h1C); A(0, 0, 0, 0); A(0, 0, 32'h1C, 4);
      M(0, 32'h20); A(0, 0, 32'h20, 4); A(0, 0, 32'h103, 4);
      M(0, 32'h106); A(0, 0, 32'h24, 0); A(0, 0, 32'h106, 4);
      M(0, 32'h10A); A(0, 0, 32'h10A, 4); A(0, 0, 0, 32'hFFFF_FFFC);
      M(0, 32'hFFFF_FFFC); A(0, 0, 0, 0); A(0, 0, 32'hFFFF_FFFC, 4);
      M(0, 0);
      tb_e = 2'b00; I(0); A(0, 0, 0, 4); I(0); I(0);
      tb_e = 2'b01; I(0); M(0, 4);

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < vt.size(); i++) begin
         rdy = vt[i].rdy; run_en = vt[i].en;
         #1;
         if (vt[i].v)
            check($sformatf("vec%0d", i), {28'b0, snap()},
                  {28'b0, 1'b1, vt[i].tid, vt[i].sel, vt[i].ctrl, vt[i].in0, vt[i].in1});
         else
            check($sformatf("vec%0d_idle", i), {126'b0, bus.unit_valid, bus.thread_id},
                  {126'b0, 1'b0, vt[i].tid});
         step();
      end

      check("halted_after_ebreak", {126'b0, halted}, {126'b0, 2'b10});
`ifdef THREAD_MT_RETIRE_CNT_EN
      check("retired_counts", {64'b0, retired}, {64'b0, 32'd3, 32'd10});
`else
      check("retired_counts", {64'b0, retired}, 128'b0);
`endif

      rdy = 1'b0; #1;
      check("stall_before_reset", {127'b0, bus.unit_valid}, 128'b1);
      rst_n = 1'b0; #1;
      check("reset_bus", {28'b0, snap()}, 128'b0);
      check("reset_status", {62'b0, halted, retired}, 128'b0);
      step(); step();
      rdy = 1'b1; run_en = 2'b11;
      rst_n = 1'b1;
      begin
         int w = 0;
         while (!bus.unit_valid && w < 4) begin step(); w++; end
      end
      check("post_reset_fetch", {28'b0, snap()}, {28'b0, 1'b1, 1'b0, MEM, 32'h0, 32'h0, 32'h0});
      step();
      check("post_reset_lui", {126'b0, bus.unit_valid, bus.thread_id}, 128'b0);
      step();
      check("post_reset_nextpc", {28'b0, snap()}, {28'b0, 1'b1, 1'b0, ALU, 32'h0, 32'h0, 32'h4});
      step();
      check("post_reset_t1_fetch", {28'b0, snap()}, {28'b0, 1'b1, 1'b1, MEM, 32'h0, 32'h0, 32'h0});
`ifdef THREAD_MT_RETIRE_CNT_EN
      check("post_reset_retired", {64'b0, retired}, {64'b0, 32'd0, 32'd1});
`else
      check("post_reset_retired", {64'b0, retired}, 128'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
